// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } ctrlState_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned INIT_CYCLES_DEF = 4;
  localparam int unsigned CNT_W           = 32;

endpackage

// File: rtl/pipe_ctrl_load_use.sv
// Load-use hazard detect: a load in EX whose destination feeds the instruction in ID.
module pipe_ctrl_load_use (
  input  logic       memRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       hazard
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = memRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable/flush controller with memory-wait timeout.
// Optional perf counters (stall_cnt, flush_cnt) enabled by macro PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             mem_timeout
);

  ctrlState_t       curState, nextState;
  logic [CNT_W-1:0] initCnt, nextInit;
  logic [CNT_W-1:0] waitCnt, nextWait;
  logic             memTimeoutR;
  logic             loadUse;
  logic             stallEv, flushEv;

  pipe_ctrl_load_use uLoadUse (
    .memRead (ex_mem_read),
    .exRt    (ex_rt),
    .idRs    (id_rs),
    .idRt    (id_rt),
    .hazard  (loadUse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState    <= INIT;
      initCnt     <= '0;
      waitCnt     <= '0;
      memTimeoutR <= 1'b0;
    end else begin
      curState <= nextState;
      initCnt  <= nextInit;
      waitCnt  <= nextWait;
      if (nextState == ERROR) memTimeoutR <= 1'b1;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    nextState   = curState;
    nextInit    = initCnt;
    nextWait    = waitCnt;
    stallEv     = 1'b0;
    flushEv     = 1'b0;
    unique case (curState)
      INIT: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
        nextInit    = initCnt + CNT_W'(1);
        if (initCnt == INIT_CYCLES - 1) begin
          nextState = RUN;
          nextInit  = '0;
        end
      end
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          stallEv     = 1'b1;
          if (curState == RUN) begin
            nextState = MEM_WAIT;
            nextWait  = CNT_W'(1);
          end else if (waitCnt == MEM_TIMEOUT) begin
            nextState = ERROR;
          end else begin
            nextWait = waitCnt + CNT_W'(1);
          end
        end else begin
          if (curState == MEM_WAIT) begin
            nextState = RUN;
            nextWait  = '0;
          end
          // A taken branch squashes ID, which also removes any load-use consumer.
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flushEv    = 1'b1;
          end else if (loadUse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stallEv    = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: nextState = INIT;
    endcase
  end

  assign state       = curState;
  assign mem_timeout = memTimeoutR;

`ifdef PIPE_CTRL_PERF_EN
  // Events are only raised in RUN/MEM_WAIT, so INIT and ERROR never count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallEv && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEv && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic unusedEv;
  assign unusedEv = stallEv ^ flushEv;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected outputs, monitor checks at negedge.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       ex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  logic [11:0] expQ[$];
  string       nameQ[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(5), .INIT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .state        (state),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .mem_timeout  (mem_timeout)
  );

  // {state, mem_timeout, pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  function automatic logic [11:0] mk(input logic [1:0] st, input logic to, input logic [4:0] en,
                                     input logic [3:0] fl);
    return {st, to, en, fl};
  endfunction

  localparam logic [11:0] O_INIT = {2'd0, 1'b0, 5'b01111, 4'b1111};
  localparam logic [11:0] O_ERR  = {2'd3, 1'b1, 5'b00000, 4'b0000};

  function automatic logic [11:0] oRun(input logic [1:0] st);
    return mk(st, 1'b0, 5'b11111, 4'b0000);
  endfunction
  function automatic logic [11:0] oLu(input logic [1:0] st);
    return mk(st, 1'b0, 5'b00111, 4'b0100);
  endfunction
  function automatic logic [11:0] oBr(input logic [1:0] st);
    return mk(st, 1'b0, 5'b11111, 4'b1100);
  endfunction
  function automatic logic [11:0] oMb(input logic [1:0] st);
    return mk(st, 1'b0, 5'b00001, 4'b0001);
  endfunction

  task automatic step(input logic rst, input logic busy, input logic br, input logic rd,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [11:0] exp, input string nm);
    @(posedge clk);
    #1;
    reset        = rst;
    mem_busy     = busy;
    branch_taken = br;
    ex_mem_read  = rd;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    expQ.push_back(exp);
    nameQ.push_back(nm);
  endtask

  task automatic idle(input logic [11:0] exp, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, exp, nm);
  endtask

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the head of the scoreboard away from the active edge.
  initial begin
    logic [11:0] e, a;
    string       n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        a = {state, mem_timeout, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush};
        nChecks++;
        if (a !== e) begin
          nFails++;
          $display("FAIL %s: got %b expected %b", n, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned drain;
    // Reset then bubble fill
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_INIT, "reset_hold");
    for (int i = 0; i < 4; i++) idle(O_INIT, "init_fill");
    idle(oRun(2'd1), "run_entry");
    idle(oRun(2'd1), "run_idle");

    // Load-use hazards
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd3, oLu(2'd1), "lu_rs");
    idle(oRun(2'd1), "lu_rs_one_cycle");
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd5, oLu(2'd1), "lu_rt");
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, oRun(2'd1), "lu_r0_none");
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, oRun(2'd1), "no_load_none");
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd7, oRun(2'd1), "lu_nomatch");

    // Branches
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, oBr(2'd1), "br_over_lu");
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, oBr(2'd1), "br_only");
    idle(oRun(2'd1), "br_one_cycle");

    // Memory busy for three cycles, busy outranks branch and load-use
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd1), "mb_c1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, oMb(2'd2), "mb_c2_prio");
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd2), "mb_c3");
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd0, 5'd6, oLu(2'd2), "mw_release_lu");
    idle(oRun(2'd1), "mw_back_run");
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    checkVal("stall_cnt", stall_cnt, 32'd6);
    checkVal("flush_cnt", flush_cnt, 32'd2);
`endif

    // Timeout: one busy cycle in RUN, then wait_cnt 1..5 in MEM_WAIT, then ERROR
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd1), "to_run");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd2), "to_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_ERR, "to_error");
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, O_ERR, "error_sticky");
    idle(O_ERR, "error_hold");
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    checkVal("stall_cnt_err", stall_cnt, 32'd12);
`endif

    // Reset exits ERROR
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_INIT, "reset_from_error");
    for (int i = 0; i < 4; i++) idle(O_INIT, "init_after_err");
    idle(oRun(2'd1), "run_after_err");

    // Reset mid-MEM_WAIT takes effect before the next clock edge
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd1), "mw2_run");
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, oMb(2'd2), "mw2_wait");
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_INIT, "async_reset_mw");
    @(negedge clk);
    checkVal("wait_cnt_cleared", dut.waitCnt, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    checkVal("stall_cnt_reset", stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 4; i++) idle(O_INIT, "init_after_mw");
    idle(oRun(2'd1), "run_after_mw");
    idle(oRun(2'd1), "run_final");

    drain = 0;
    while (expQ.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum consecutive mem_busy cycles tolerated before the error state.
REQ-002 SHALL have parameter INIT_CYCLES, default 4: number of bubble-fill cycles after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have ports ex_mem_read (input, 1) and ex_rt (input, 5)  load flag and destination of the instruction in EX.
REQ-007 SHALL have port branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-008 SHALL have port mem_busy  input  1  data memory not ready for the access in MEM.
REQ-009 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en  1 each  latch/PC load enables.
REQ-010 SHALL have outputs ifid_flush, idex_flush, exmem_flush, memwb_flush  1 each  force bubble (RegWrite=0, MemtoReg=0) into that latch.
REQ-011 SHALL have outputs state (2 bits, current FSM state) and mem_timeout (1 bit, sticky error).

Function
REQ-012 SHALL implement the FSM states INIT=0, RUN=1, MEM_WAIT=2, ERROR=3, registered, with Mealy outputs computed from the registered state and the current inputs.
REQ-013 In INIT: pc_en=0; all latch enables=1; all flushes=1; init_cnt increments each cycle; after INIT_CYCLES cycles (cnt==INIT_CYCLES-1) next state RUN.
REQ-014 In RUN/MEM_WAIT, default outputs: all enables=1, all flushes=0.
REQ-015 Priority in RUN/MEM_WAIT: mem_busy > branch_taken > load-use.
REQ-016 While mem_busy=1: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1, memwb_flush=1; other flushes=0.
REQ-017 On mem_busy=1 in RUN, next state SHALL be MEM_WAIT with wait_cnt=1; in MEM_WAIT, wait_cnt SHALL increment per mem_busy cycle.
REQ-018 In MEM_WAIT, mem_busy=0 SHALL give default outputs that cycle and next state RUN, with wait_cnt cleared.
REQ-019 In MEM_WAIT, if mem_busy=1 and wait_cnt==MEM_TIMEOUT, next state SHALL be ERROR.
REQ-020 On branch_taken=1 (mem_busy=0): ifid_flush=1, idex_flush=1, pc_en=1; the stall lasts one cycle only, with no state change.
REQ-021 Load-use condition: ex_mem_read=1 and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
REQ-022 On load-use (no higher priority event): pc_en=0, ifid_en=0, idex_flush=1, for one cycle.
REQ-023 Branch with load-use in the same cycle: the branch wins, no stall, and ID is squashed.
REQ-024 In ERROR: all enables=0, all flushes=0, mem_timeout=1; only reset exits ERROR.

Reset
REQ-025 Asserting reset at any time SHALL immediately force: state=INIT, init_cnt=0, wait_cnt=0, mem_timeout=0.
REQ-026 During reset, outputs SHALL equal INIT outputs: pc_en=0, all enables=1, all flushes=1.
REQ-027 Reset during MEM_WAIT or ERROR SHALL discard all pending stall and error history.

Configuration
REQ-028 With macro PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-029 stall_cnt SHALL count load-use and mem_busy stall cycles; flush_cnt SHALL count branch-flush cycles.
REQ-030 Both counters SHALL saturate at 0xFFFFFFFF, reset to 0, and not count in INIT or ERROR.
REQ-031 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the state encoding constants, the MEM_TIMEOUT and INIT_CYCLES defaults, and the counter width.
REQ-033 The load-use comparison SHALL be one combinational sub-module, pipe_ctrl_load_use, instantiated once.

Verification
REQ-034 Reset then release -> 4 cycles with flushes=1, pc_en=0; then state=1 and pc_en=1.
REQ-035 ex_mem_read=1, ex_rt=8, id_rs=8 in RUN -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; with ex_rt=0 -> no stall.
REQ-036 mem_busy high 3 cycles -> 3 cycles of exmem_en=0 and memwb_flush=1, state=2, then RUN; with PERF, stall_cnt=3.
REQ-037 branch_taken with load-use in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, no stall.
REQ-038 MEM_TIMEOUT=5, mem_busy held -> ERROR after wait_cnt reaches 5, mem_timeout=1 and all enables=0; reset clears it.
REQ-039 Reset asserted mid-MEM_WAIT -> state=0 asynchronously and wait_cnt=0.
